// File: rtl/pdm_decimator_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pdm_decimator_pkg : widths and defaults shared by the PDM audio path. r1.0 |
// +----------------------------------------------------------------------------+
package pdm_decimator_pkg;

  // Shared with the modulator's N so both ends agree on the PCM width.
  localparam int AUDIO_SAMPLE_W   = 12;
  localparam int AUDIO_DECIM_LOG2 = 5;
  localparam int AUDIO_WARMUP     = 3;

  function automatic int cic_acc_width(input int decim_log2);
    return 3 * decim_log2 + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pdm_decimator_cic_comb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pdm_decimator_cic_comb_stage : one CIC comb (c = x - x_delayed).     r1.0  |
// +----------------------------------------------------------------------------+
module pdm_decimator_cic_comb_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o
);

  logic [W-1:0] c_q;
  logic [W-1:0] d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q <= '0;
      d_q <= '0;
    end else if (en_i) begin
      c_q <= data_i - d_q;
      d_q <= data_i;
    end
  end

  assign data_o = c_q;

endmodule
`default_nettype wire

// File: rtl/pdm_decimator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pdm_decimator : 1-bit PDM to unsigned PCM, 3rd-order CIC, valid/ready. r1.0|
// +----------------------------------------------------------------------------+
module pdm_decimator
  import pdm_decimator_pkg::*;
#(
  parameter int DECIM_LOG2 = AUDIO_DECIM_LOG2,
  parameter int OUT_W      = AUDIO_SAMPLE_W,
  parameter int WARMUP     = AUDIO_WARMUP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_en,
  input  logic             pdm_in,
  input  logic             sample_ready,
  output logic             sample_valid,
  output logic [OUT_W-1:0] sample_out,
  output logic             overrun
);

  localparam int ACC_W  = cic_acc_width(DECIM_LOG2);
  localparam int SHIFT  = 3 * DECIM_LOG2 - OUT_W;
  localparam int WARM_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(WARMUP);

  logic [1:0]            sync_q;
  logic                  pdm_s;
  logic [DECIM_LOG2-1:0] ph_q;
  logic [ACC_W-1:0]      i1_q;
  logic [ACC_W-1:0]      i2_q;
  logic [ACC_W-1:0]      i3_q;
  logic                  tick;

  assign pdm_s = sync_q[1];
  assign tick  = sample_en && (ph_q == {DECIM_LOG2{1'b1}});

  // Integrators wrap modulo 2^ACC_W; the comb differences cancel the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      ph_q   <= '0;
      i1_q   <= '0;
      i2_q   <= '0;
      i3_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], pdm_in};
      if (sample_en) begin
        ph_q <= ph_q + 1'b1;
        i1_q <= i1_q + ACC_W'(pdm_s);
        i2_q <= i2_q + i1_q;
        i3_q <= i3_q + i2_q;
      end
    end
  end

  logic [ACC_W-1:0] comb_w [0:3];

  assign comb_w[0] = i3_q;

  for (genvar gi = 0; gi < 3; gi++) begin : g_comb
    pdm_decimator_cic_comb_stage #(
      .W (ACC_W)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (tick),
      .data_i (comb_w[gi]),
      .data_o (comb_w[gi+1])
    );
  end

  logic [WARM_W-1:0] warm_q;
  logic              warm_done;
  logic              load;
  logic [ACC_W-1:0]  scaled;
  logic [OUT_W-1:0]  sat_sample;

  assign warm_done  = (warm_q == WARM_DONE);
  assign load       = tick && warm_done;
  assign scaled     = comb_w[3] >> SHIFT;
  // DC full scale lands exactly on 2^OUT_W, one past the top code.
  assign sat_sample = (|scaled[ACC_W-1:OUT_W]) ? {OUT_W{1'b1}} : scaled[OUT_W-1:0];

  logic             valid_q;
  logic             valid_d;
  logic [OUT_W-1:0] out_q;
  logic [OUT_W-1:0] out_d;
  logic             ovr_q;
  logic             ovr_d;

  always_comb begin
    valid_d = valid_q;
    out_d   = out_q;
    ovr_d   = ovr_q;
    if (load) begin
      out_d   = sat_sample;
      valid_d = 1'b1;
      if (valid_q && !sample_ready) begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_q  <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      if (tick && !warm_done) begin
        warm_q <= warm_q + 1'b1;
      end
      valid_q <= valid_d;
      out_q   <= out_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sample_valid = valid_q;
  assign sample_out   = out_q;
  assign overrun      = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_pdm_decimator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pdm_decimator : randomized bench with an impulse-response CIC model. r1.0|
// +----------------------------------------------------------------------------+
module tb_pdm_decimator;

  localparam int R      = 32;
  localparam int WARMUP = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_en = 1'b0;
  logic        pdm_in = 1'b0;
  logic        sample_ready = 1'b0;
  logic        sample_valid;
  logic [11:0] sample_out;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pdm_decimator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_en    (sample_en),
    .pdm_in       (pdm_in),
    .sample_ready (sample_ready),
    .sample_valid (sample_valid),
    .sample_out   (sample_out),
    .overrun      (overrun)
  );

  // Reference: each decimated value is a third difference of the triple
  // running sum of consumed bits, evaluated directly from the bit history.
  bit          xs[$];
  bit [15:0]   s_hist[$];
  int          n_ticks;
  bit          m_load;
  bit          m_valid;
  bit          m_ovr;
  bit [11:0]   m_out;

  function automatic bit [15:0] triple_sum(input int n);
    bit [15:0] acc = 16'd0;
    for (int j = 0; j < n; j++) begin
      if (xs[j]) acc = acc + 16'(((n - 1 - j) * (n - 2 - j)) / 2);
    end
    return acc;
  endfunction

  function automatic bit [15:0] s_at(input int m);
    return (m <= 0) ? 16'd0 : s_hist[m-1];
  endfunction

  function automatic bit [11:0] expected_sample(input int m);
    bit [15:0] raw;
    bit [15:0] sh;
    raw = 16'(s_at(m - 3) - 16'd3 * s_at(m - 4) + 16'd3 * s_at(m - 5) - s_at(m - 6));
    sh  = raw >> 3;
    return (sh > 16'd4095) ? 12'd4095 : sh[11:0];
  endfunction

  task automatic model_clear();
    xs.delete();
    s_hist.delete();
    n_ticks = 0;
    m_load  = 1'b0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_out   = 12'd0;
  endtask

  task automatic clk_step(input bit en);
    int e;
    sample_en = en;
    @(posedge clk);
    m_load = 1'b0;
    if (en) begin
      e = xs.size();
      if (e % R == R - 1) begin
        n_ticks++;
        s_hist.push_back(triple_sum(e));
        if (n_ticks > WARMUP) m_load = 1'b1;
      end
      xs.push_back(pdm_in);
    end
    if (m_load) begin
      if (m_valid && !sample_ready) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_out   = expected_sample(n_ticks);
    end else if (m_valid && sample_ready) begin
      m_valid = 1'b0;
    end
    #1;
    sample_en = 1'b0;
  endtask

  task automatic feed(input bit b, input int gap);
    pdm_in = b;
    repeat (gap - 1) clk_step(1'b0);
    clk_step(1'b1);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    #2;
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d want 0", sample_valid); end
    checks++; if (sample_out !== 12'd0) begin errors++; $display("FAIL reset_out got %0d want 0", sample_out); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %0d want 0", overrun); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_all_ones();
    int nvalid = 0;
    logic [11:0] prev = 12'd0;
    do_reset();
    sample_ready = 1'b1;
    for (int k = 0; k < 10 * R; k++) begin
      feed(1'b1, 25);
      checks++; if (sample_valid !== m_valid) begin errors++; $display("FAIL ones_valid k=%0d got %0d want %0d", k, sample_valid, m_valid); end
      if (m_load) begin
        nvalid++;
        checks++; if (sample_out !== m_out) begin errors++; $display("FAIL ones_sample n=%0d got %0d want %0d", nvalid, sample_out, m_out); end
        checks++; if (sample_out < prev) begin errors++; $display("FAIL ones_monotonic n=%0d got %0d want >= %0d", nvalid, sample_out, prev); end
        if (nvalid >= 6) begin
          checks++; if (sample_out !== 12'd4095) begin errors++; $display("FAIL ones_fullscale n=%0d got %0d want 4095", nvalid, sample_out); end
        end
        prev = sample_out;
      end
    end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ones_overrun got %0d want 0", overrun); end
  endtask

  task automatic test_all_zeros();
    bit exp_v;
    do_reset();
    sample_ready = 1'b1;
    for (int k = 0; k < 6 * R; k++) begin
      feed(1'b0, 4);
      exp_v = (k % R == R - 1) && (k / R >= WARMUP);
      checks++; if (sample_valid !== exp_v) begin errors++; $display("FAIL zeros_valid k=%0d got %0d want %0d", k, sample_valid, exp_v); end
      if (exp_v) begin
        checks++; if (sample_out !== 12'd0) begin errors++; $display("FAIL zeros_sample k=%0d got %0d want 0", k, sample_out); end
      end
    end
  endtask

  task automatic test_alternating();
    do_reset();
    sample_ready = 1'b1;
    for (int k = 0; k < 10 * R; k++) begin
      feed(k[0], 3);
      if (m_load) begin
        checks++; if (sample_out !== m_out) begin errors++; $display("FAIL alt_sample tick=%0d got %0d want %0d", n_ticks, sample_out, m_out); end
        if (n_ticks >= 7) begin
          checks++; if (sample_out !== 12'd2048) begin errors++; $display("FAIL alt_steady tick=%0d got %0d want 2048", n_ticks, sample_out); end
        end
      end
    end
  endtask

  task automatic test_loopback();
    int mod_acc = 0;
    bit b;
    do_reset();
    sample_ready = 1'b1;
    for (int k = 0; k < 12 * R; k++) begin
      mod_acc = mod_acc + 1000;
      b = (mod_acc >= 4096);
      if (b) mod_acc = mod_acc - 4096;
      feed(b, 3);
      if (m_load) begin
        checks++; if (sample_out !== m_out) begin errors++; $display("FAIL loop_sample tick=%0d got %0d want %0d", n_ticks, sample_out, m_out); end
        if (n_ticks >= 8) begin
          checks++;
          if (int'(sample_out) < 992 || int'(sample_out) > 1008) begin
            errors++; $display("FAIL loop_level tick=%0d got %0d want 1000+-8", n_ticks, sample_out);
          end
        end
      end
    end
  endtask

  task automatic test_overrun();
    int guard = 0;
    do_reset();
    sample_ready = 1'b1;
    while (n_ticks < 6 && guard < 8 * R) begin feed(1'($urandom_range(0, 1)), 3); guard++; end
    clk_step(1'b0);
    sample_ready = 1'b0;
    while (n_ticks < 7 && guard < 9 * R) begin feed(1'($urandom_range(0, 1)), 3); guard++; end
    checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL ovr_first_valid got %0d want 1", sample_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_first_flag got %0d want 0", overrun); end
    checks++; if (sample_out !== expected_sample(7)) begin errors++; $display("FAIL ovr_first_sample got %0d want %0d", sample_out, expected_sample(7)); end
    while (n_ticks < 8 && guard < 10 * R) begin feed(1'($urandom_range(0, 1)), 3); guard++; end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %0d want 1", overrun); end
    checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %0d want 1", sample_valid); end
    checks++; if (sample_out !== expected_sample(8)) begin errors++; $display("FAIL ovr_second_sample got %0d want %0d", sample_out, expected_sample(8)); end
    sample_ready = 1'b1;
    clk_step(1'b0);
    sample_ready = 1'b0;
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain_valid got %0d want 0", sample_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %0d want 1", overrun); end
    clk_step(1'b0);
    checks++; if (overrun !== 1'b1 || sample_valid !== 1'b0) begin
      errors++; $display("FAIL ovr_hold got ovr=%0d valid=%0d want ovr=1 valid=0", overrun, sample_valid);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 12 * R; k++) begin
      sample_ready = ($urandom_range(0, 3) != 0);
      feed(1'($urandom_range(0, 1)), int'($urandom_range(3, 6)));
      checks++; if (sample_valid !== m_valid) begin errors++; $display("FAIL rand_valid k=%0d got %0d want %0d", k, sample_valid, m_valid); end
      checks++; if (sample_out !== m_out) begin errors++; $display("FAIL rand_sample k=%0d got %0d want %0d", k, sample_out, m_out); end
      checks++; if (overrun !== m_ovr) begin errors++; $display("FAIL rand_overrun k=%0d got %0d want %0d", k, overrun, m_ovr); end
    end
    sample_ready = 1'b0;
  endtask

  task automatic test_midstream_reset();
    bit exp_v;
    do_reset();
    sample_ready = 1'b0;
    for (int k = 0; k < 6 * R + 5; k++) feed(1'b1, 3);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL mid_pre_overrun got %0d want 1", overrun); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid got %0d want 0", sample_valid); end
    checks++; if (sample_out !== 12'd0) begin errors++; $display("FAIL mid_async_out got %0d want 0", sample_out); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL mid_async_overrun got %0d want 0", overrun); end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    sample_ready = 1'b1;
    for (int k = 0; k < 4 * R; k++) begin
      feed(1'b1, 3);
      exp_v = (k % R == R - 1) && (k / R >= WARMUP);
      checks++; if (sample_valid !== exp_v) begin errors++; $display("FAIL mid_warmup_valid k=%0d got %0d want %0d", k, sample_valid, exp_v); end
    end
    checks++; if (sample_out !== expected_sample(4)) begin errors++; $display("FAIL mid_first_sample got %0d want %0d", sample_out, expected_sample(4)); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_all_ones();
    test_all_zeros();
    test_alternating();
    test_loopback();
    test_overrun();
    test_random();
    test_midstream_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
